muldiv_sequencer: RTL
=====================

Name: muldiv_sequencer

Overview:
- Multi-cycle RV32M multiply/divide unit for the execute stage. It runs alongside the single-cycle ALU.
- Accepts one operation per start pulse and runs a shift-add multiply or restoring divide, one bit per cycle.
- Returns a registered result with a one-cycle done pulse.
- Drives busy so the hazard/stall logic can freeze the pipeline while an operation is in flight.

Parameters:
- WIDTH, 32, operand and result width in bits; the iteration count equals WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  synchronous reset, active-low; sampled on rising edge of clk.
- start  input  1  request a new operation; accepted only when ready=1.
- Funct3  input  3  M-extension selector (bits 14:12 of the instruction).
- SrcA  input  WIDTH  rs1 operand (multiplicand / dividend).
- SrcB  input  WIDTH  rs2 operand (multiplier / divisor).
- kill  input  1  abort the in-flight operation (pipeline flush).
- ready  output  1  high in IDLE only.
- busy  output  1  high in CALC and FIXUP.
- done  output  1  one-cycle pulse; Result valid in that cycle.
- Result  output  WIDTH  registered result; holds until the next done.

Behaviour:
- Funct3 encoding:
  - 000 MUL (low word), 001 MULH (s×s high), 010 MULHSU (s×u high), 011 MULHU (u×u high).
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- States: IDLE, CALC, FIXUP, DONE. Reset (rst_n=0 at an edge) forces IDLE, counter=0, Result=0, done=0, busy=0, ready=1. This applies regardless of current state, including mid-operation.
- IDLE, start=1:
  - Latch Funct3.
  - Latch the magnitudes of SrcA/SrcB: signed operands are negated if negative; for MULHSU only SrcA is treated as signed.
  - Latch the result sign:
    - Multiply: sign(A) xor sign(B) over the signed operands.
    - Quotient: sign(A) xor sign(B).
    - Remainder: sign(A).
  - Clear the 2×WIDTH accumulator and counter.
  - Next state is CALC, or FIXUP directly for special divide cases.
- Special divide cases, checked at start:
  - Divisor = 0: quotient = all ones, remainder = SrcA.
  - Signed overflow (DIV/REM with SrcA = 100…0 and SrcB = all ones): quotient = SrcA, remainder = 0.
  - Both bypass CALC.
- CALC: one iteration per cycle, counter 0..WIDTH-1; after iteration WIDTH-1, go to FIXUP.
  - Multiply: if the multiplier LSB is 1, add the multiplicand into the accumulator high half; shift right by one.
  - Divide (restoring): shift remainder:quotient left by one; trial-subtract the divisor; if the result is non-negative, keep it and set the quotient LSB.
- FIXUP (1 cycle):
  - Select the low or high word, or the quotient or remainder.
  - Apply two's-complement negation if the latched sign is 1.
  - Register Result; go to DONE.
- DONE (1 cycle): done=1; start is ignored; unconditional transition to IDLE.
- Latency from the start-accept edge: done is high in cycle WIDTH+2 (34 for WIDTH=32); special divide cases assert done in cycle 2. Back-to-back throughput is one operation per WIDTH+3 cycles.
- kill=1 in CALC or FIXUP: next state is IDLE; done is not asserted and Result is unchanged. kill in IDLE or DONE has no effect. kill and start together in IDLE: kill wins and the start is dropped.
- start while not in IDLE: ignored; the requester must hold start until ready.
- All arithmetic is modulo 2^WIDTH; no flags are produced.

Test Plan:
- MUL SrcA=7, SrcB=0xFFFFFFFD -> Result=0xFFFFFFEB; done exactly 34 cycles after the start edge; busy high for cycles 1-33.
- MULH 0x80000000×0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 5, done in cycle 2; DIV 0x80000000/0xFFFFFFFF -> 0x80000000 and REM -> 0, done in cycle 2.
- kill asserted in CALC cycle 10 -> IDLE next cycle, no done pulse, Result retains its previous value; a new start is then accepted normally.
- rst_n=0 in CALC cycle 5 -> next edge: IDLE, Result=0, busy=0, ready=1; start during DONE is ignored and produces no second operation.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle RV32M multiply/divide unit.
// Shift-add multiply and restoring divide, one bit per cycle, on operand
// magnitudes; the sign is reapplied in a single FIXUP cycle. The divide
// special cases (divide by zero, signed overflow) skip the iteration.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             kill,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Result
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALC  = 2'd1,
    FIXUP = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t stateNext;

  // Latched operation context
  logic [2:0]         op;
  logic               resSign;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   aSh;
  logic [WIDTH-1:0]   bSh;
  logic [2*WIDTH-1:0] acc;

  // Start-time decode of the incoming operation
  logic               isDivIn;
  logic               aSignedIn;
  logic               bSignedIn;
  logic               aNegIn;
  logic               bNegIn;
  logic [WIDTH-1:0]   aMagIn;
  logic [WIDTH-1:0]   bMagIn;
  logic               divZero;
  logic               divOvf;
  logic               specialIn;
  logic               signIn;
  logic               accept;

  // Per-iteration datapath and final result selection
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulNext;
  logic [WIDTH:0]     divPart;
  logic [WIDTH:0]     divTrial;
  logic [2*WIDTH-1:0] divNext;
  logic [2*WIDTH-1:0] prodSel;
  logic [WIDTH-1:0]   divWord;
  logic [WIDTH-1:0]   fixResult;
  logic               lastIter;

  // Decode signedness, magnitudes, result sign and divide special cases
  // from the live inputs; these only matter on the cycle a start is accepted.
  always_comb begin
    isDivIn   = Funct3[2];
    aSignedIn = 1'b0;
    bSignedIn = 1'b0;
    if (isDivIn) begin
      aSignedIn = ~Funct3[0];
      bSignedIn = ~Funct3[0];
    end else begin
      aSignedIn = (Funct3[1:0] == 2'b01) || (Funct3[1:0] == 2'b10);
      bSignedIn = (Funct3[1:0] == 2'b01);
    end
    aNegIn = aSignedIn & SrcA[WIDTH-1];
    bNegIn = bSignedIn & SrcB[WIDTH-1];
    aMagIn = aNegIn ? (~SrcA + WIDTH'(1)) : SrcA;
    bMagIn = bNegIn ? (~SrcB + WIDTH'(1)) : SrcB;

    divZero = isDivIn && (SrcB == '0);
    divOvf  = isDivIn && ~Funct3[0] && ~divZero &&
              (SrcA == {1'b1, {(WIDTH-1){1'b0}}}) && (SrcB == '1);
    specialIn = divZero || divOvf;

    // Remainder follows the dividend; product and quotient use the xor
    if (isDivIn && Funct3[1]) begin
      signIn = aNegIn;
    end else begin
      signIn = aNegIn ^ bNegIn;
    end

    accept = (state == IDLE) && start && !kill;
  end

  // One iteration of shift-add multiply or restoring divide, plus the
  // FIXUP-cycle selection and sign correction of the final word.
  always_comb begin
    mulSum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (bSh[0] ? {1'b0, aSh} : '0);
    mulNext = {mulSum, acc[WIDTH-1:1]};

    divPart  = {acc[2*WIDTH-1:WIDTH], aSh[WIDTH-1]};
    divTrial = divPart - {1'b0, bSh};
    if (divTrial[WIDTH]) begin
      divNext = {divPart[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      divNext = {divTrial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    // A signed product must be negated as a whole before picking a half
    prodSel = resSign ? (~acc + (2*WIDTH)'(1)) : acc;
    divWord = op[1] ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];

    fixResult = '0;
    if (op[2]) begin
      fixResult = resSign ? (~divWord + WIDTH'(1)) : divWord;
    end else if (op[1:0] == 2'b00) begin
      fixResult = prodSel[WIDTH-1:0];
    end else begin
      fixResult = prodSel[2*WIDTH-1:WIDTH];
    end

    lastIter = (cnt == CW'(WIDTH - 1));
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state logic; kill aborts CALC/FIXUP and beats a same-cycle start
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (accept) begin
          stateNext = specialIn ? FIXUP : CALC;
        end
      end
      CALC: begin
        if (kill) begin
          stateNext = IDLE;
        end else if (lastIter) begin
          stateNext = FIXUP;
        end
      end
      FIXUP: begin
        stateNext = kill ? IDLE : DONE;
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Status outputs are pure decodes of the registered state
  always_comb begin
    ready = (state == IDLE);
    busy  = (state == CALC) || (state == FIXUP);
    done  = (state == DONE);
  end

  // Operand/accumulator datapath and the held Result register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op      <= '0;
      resSign <= 1'b0;
      cnt     <= '0;
      aSh     <= '0;
      bSh     <= '0;
      acc     <= '0;
      Result  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op      <= Funct3;
            resSign <= specialIn ? 1'b0 : signIn;
            cnt     <= '0;
            aSh     <= aMagIn;
            bSh     <= bMagIn;
            if (divZero) begin
              acc <= {SrcA, {WIDTH{1'b1}}};
            end else if (divOvf) begin
              acc <= {{WIDTH{1'b0}}, SrcA};
            end else begin
              acc <= '0;
            end
          end
        end
        CALC: begin
          cnt <= cnt + CW'(1);
          if (op[2]) begin
            aSh <= {aSh[WIDTH-2:0], 1'b0};
            acc <= divNext;
          end else begin
            bSh <= {1'b0, bSh[WIDTH-1:1]};
            acc <= mulNext;
          end
        end
        FIXUP: begin
          if (!kill) begin
            Result <= fixResult;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
